// File: rtl/seg7_capture.sv
// Reads back a multiplexed active-low seven-segment bus and reconstructs the
// hex value on each digit, committing only after a run of identical samples.
module seg7_capture #(
  parameter int NUM_DIGITS   = 4,
  parameter int STABLE_COUNT = 3,
  parameter int CNT_W        = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    SAMPLE_EN,
  input  logic [6:0]              SEGMENTS,
  input  logic [NUM_DIGITS-1:0]   DIGIT_SEL_N,
  output logic [4*NUM_DIGITS-1:0] DATA,
  output logic [NUM_DIGITS-1:0]   DIGIT_VALID,
  output logic [NUM_DIGITS-1:0]   DIGIT_ERR,
  output logic                    UPDATE
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_COUNT);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_COUNT - 1);

  logic [4*NUM_DIGITS-1:0] data_q;
  logic [NUM_DIGITS-1:0]   valid_q;
  logic [NUM_DIGITS-1:0]   err_q;
  logic                    update_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [IDX_W-1:0]        last_idx_q;
  logic [6:0]              last_seg_q;

  logic [NUM_DIGITS-1:0] sel;
  logic                  sel_one;
  logic [IDX_W-1:0]      idx;
  logic                  match;
  logic [3:0]            dec_nib;
  logic                  dec_legal;
  logic                  dec_blank;
  logic [3:0]            cur_nib;
  logic [3:0]            new_nib;
  logic                  new_err;
  logic                  changed;

  // Segment pattern to nibble; the inverse of the display encoder.
  always_comb begin
    dec_nib   = 4'h0;
    dec_legal = 1'b1;
    dec_blank = 1'b0;
    case (SEGMENTS)
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h18: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
      7'h7F: begin
        dec_legal = 1'b0;
        dec_blank = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // A sample qualifies only when exactly one select is driven low.
  always_comb begin
    sel     = ~DIGIT_SEL_N;
    sel_one = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
    idx     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel[i]) idx = IDX_W'(i);
    end
  end

  always_comb begin
    match   = (idx == last_idx_q) && (SEGMENTS == last_seg_q);
    cur_nib = data_q[4*idx +: 4];
    new_nib = dec_legal ? dec_nib : cur_nib;
    new_err = !dec_legal && !dec_blank;
    changed = (new_nib != cur_nib) || (dec_legal != valid_q[idx]) ||
              (new_err != err_q[idx]);
  end

  // UPDATE is a single-cycle strobe with no back-pressure: it is high for the
  // one cycle after a commit that altered that digit's DATA/VALID/ERR.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      data_q     <= '0;
      valid_q    <= '0;
      err_q      <= '0;
      update_q   <= 1'b0;
      cnt_q      <= '0;
      last_idx_q <= '0;
      last_seg_q <= '0;
    end else begin
      update_q <= 1'b0;
      if (SAMPLE_EN) begin
        if (!sel_one) begin
          cnt_q <= '0;
        end else if (match) begin
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
          // Commit only on the transition into STABLE_COUNT, never while saturated.
          if (cnt_q == CNT_PRE) begin
            data_q[4*idx +: 4] <= new_nib;
            valid_q[idx]       <= dec_legal;
            err_q[idx]         <= new_err;
            update_q           <= changed;
          end
        end else begin
          last_idx_q <= idx;
          last_seg_q <= SEGMENTS;
          cnt_q      <= CNT_W'(1);
        end
      end
    end
  end

  assign DATA        = data_q;
  assign DIGIT_VALID = valid_q;
  assign DIGIT_ERR   = err_q;
  assign UPDATE      = update_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: a monitor pops expected {DATA,VALID,ERR}
// words on every UPDATE pulse; direct checks cover non-commit windows.
module tb_seg7_capture;

  localparam int W = 24;

  logic        clk;
  logic        RESET;
  logic        SAMPLE_EN;
  logic [6:0]  SEGMENTS;
  logic [3:0]  DIGIT_SEL_N;
  logic [15:0] DATA;
  logic [3:0]  DIGIT_VALID;
  logic [3:0]  DIGIT_ERR;
  logic        UPDATE;

  logic [W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  seg7_capture #(
    .NUM_DIGITS(4),
    .STABLE_COUNT(3),
    .CNT_W(4)
  ) dut (
    .CLK(clk),
    .RESET(RESET),
    .SAMPLE_EN(SAMPLE_EN),
    .SEGMENTS(SEGMENTS),
    .DIGIT_SEL_N(DIGIT_SEL_N),
    .DATA(DATA),
    .DIGIT_VALID(DIGIT_VALID),
    .DIGIT_ERR(DIGIT_ERR),
    .UPDATE(UPDATE)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] exp;
    if (UPDATE === 1'b1) begin
      act = {DATA, DIGIT_VALID, DIGIT_ERR};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL update_unexpected: got %h, required no UPDATE", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          fails++;
          $display("FAIL update_value: got %h, required %h", act, exp);
        end
      end
    end
  end

  // driver tasks
  task automatic sample(input logic [3:0] sel, input logic [6:0] seg);
    @(negedge clk);
    SAMPLE_EN   = 1'b1;
    DIGIT_SEL_N = sel;
    SEGMENTS    = seg;
    @(negedge clk);
    SAMPLE_EN   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_commit(input logic [15:0] d, input logic [3:0] v, input logic [3:0] e);
    exp_q.push_back({d, v, e});
  endtask

  task automatic check(input string name, input logic [15:0] d, input logic [3:0] v,
                       input logic [3:0] e, input logic u);
    tests++;
    if ({DATA, DIGIT_VALID, DIGIT_ERR, UPDATE} !== {d, v, e, u}) begin
      fails++;
      $display("FAIL %s: got data=%h valid=%b err=%b upd=%b, required data=%h valid=%b err=%b upd=%b",
               name, DATA, DIGIT_VALID, DIGIT_ERR, UPDATE, d, v, e, u);
    end
  endtask

  initial begin
    RESET       = 1'b1;
    SAMPLE_EN   = 1'b0;
    SEGMENTS    = 7'h7F;
    DIGIT_SEL_N = 4'hF;
    idle(3);
    RESET = 1'b0;
    idle(1);
    check("reset", 16'h0000, 4'b0000, 4'b0000, 1'b0);

    // digit 0 shows 2
    sample(4'b1110, 7'h24);
    sample(4'b1110, 7'h24);
    check("t1_pre", 16'h0000, 4'b0000, 4'b0000, 1'b0);
    expect_commit(16'h0002, 4'b0001, 4'b0000);
    sample(4'b1110, 7'h24);
    check("t1_commit", 16'h0002, 4'b0001, 4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) sample(4'b1110, 7'h24);
    check("t1_hold", 16'h0002, 4'b0001, 4'b0000, 1'b0);

    // digit 1: 5, then 6, then 5/6 alternation
    sample(4'b1101, 7'h12);
    sample(4'b1101, 7'h12);
    expect_commit(16'h0052, 4'b0011, 4'b0000);
    sample(4'b1101, 7'h12);
    check("t2_five", 16'h0052, 4'b0011, 4'b0000, 1'b1);
    sample(4'b1101, 7'h02);
    sample(4'b1101, 7'h02);
    check("t2_six_pre", 16'h0052, 4'b0011, 4'b0000, 1'b0);
    expect_commit(16'h0062, 4'b0011, 4'b0000);
    sample(4'b1101, 7'h02);
    check("t2_six", 16'h0062, 4'b0011, 4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      sample(4'b1101, 7'h12);
      sample(4'b1101, 7'h02);
    end
    check("t2_alternate", 16'h0062, 4'b0011, 4'b0000, 1'b0);

    // recommit of an identical value gives no UPDATE
    sample(4'b1110, 7'h24);
    for (int i = 0; i < 3; i++) sample(4'b1101, 7'h02);
    check("t2_same_value", 16'h0062, 4'b0011, 4'b0000, 1'b0);

    // digit 2: illegal, then blank
    sample(4'b1011, 7'h55);
    sample(4'b1011, 7'h55);
    expect_commit(16'h0062, 4'b0011, 4'b0100);
    sample(4'b1011, 7'h55);
    check("t3_illegal", 16'h0062, 4'b0011, 4'b0100, 1'b1);
    sample(4'b1011, 7'h7F);
    sample(4'b1011, 7'h7F);
    expect_commit(16'h0062, 4'b0011, 4'b0000);
    sample(4'b1011, 7'h7F);
    check("t3_blank", 16'h0062, 4'b0011, 4'b0000, 1'b1);

    // discarded samples (two selects low, no select low) restart the count
    sample(4'b0111, 7'h30);
    sample(4'b0111, 7'h30);
    sample(4'b1100, 7'h30);
    sample(4'b0111, 7'h30);
    sample(4'b0111, 7'h30);
    check("t4_multi_sel", 16'h0062, 4'b0011, 4'b0000, 1'b0);
    expect_commit(16'h3062, 4'b1011, 4'b0000);
    sample(4'b0111, 7'h30);
    check("t4_multi_commit", 16'h3062, 4'b1011, 4'b0000, 1'b1);
    sample(4'b1110, 7'h19);
    sample(4'b1110, 7'h19);
    sample(4'b1111, 7'h19);
    sample(4'b1110, 7'h19);
    sample(4'b1110, 7'h19);
    check("t4_no_sel", 16'h3062, 4'b1011, 4'b0000, 1'b0);
    expect_commit(16'h3064, 4'b1011, 4'b0000);
    sample(4'b1110, 7'h19);
    check("t4_no_sel_commit", 16'h3064, 4'b1011, 4'b0000, 1'b1);

    // idle gaps do not break stability
    sample(4'b0111, 7'h0E);
    idle(4);
    sample(4'b0111, 7'h0E);
    idle(4);
    check("t5_pre", 16'h3064, 4'b1011, 4'b0000, 1'b0);
    expect_commit(16'hF064, 4'b1011, 4'b0000);
    sample(4'b0111, 7'h0E);
    check("t5_commit", 16'hF064, 4'b1011, 4'b0000, 1'b1);

    // reset mid-count, coincident with a sample
    sample(4'b1011, 7'h08);
    sample(4'b1011, 7'h08);
    @(negedge clk);
    RESET       = 1'b1;
    SAMPLE_EN   = 1'b1;
    DIGIT_SEL_N = 4'b1011;
    SEGMENTS    = 7'h08;
    @(negedge clk);
    RESET       = 1'b0;
    SAMPLE_EN   = 1'b0;
    check("t6_reset", 16'h0000, 4'b0000, 4'b0000, 1'b0);
    sample(4'b1011, 7'h08);
    check("t6_one_sample", 16'h0000, 4'b0000, 4'b0000, 1'b0);
    sample(4'b1011, 7'h08);
    expect_commit(16'h0A00, 4'b0100, 4'b0000);
    sample(4'b1011, 7'h08);
    check("t6_commit", 16'h0A00, 4'b0100, 4'b0000, 1'b1);

    idle(3);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_updates: got %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
